alu_result_display: RTL



---
 rtl/alu_disp_pkg.sv | 40 ++++
 rtl/alu_result_display_seg7.sv | 32 +++
 rtl/alu_result_display.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/alu_disp_pkg.sv
// -----------------------------------------------------------------------------
// alu_disp_pkg
// Shared definitions for the ALU result display stage:
//   - active-high seven-segment patterns, bit order {g,f,e,d,c,b,a}
//   - special digit codes understood by seg7_encode (minus, blank)
//   - converter FSM state encoding
//   - BCD nibble adjust helper used by the double-dabble engine
// -----------------------------------------------------------------------------
package alu_disp_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] CODE_MINUS = 4'd10;
    localparam logic [3:0] CODE_BLANK = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } conv_state_e;

    // Double-dabble correction: a nibble of 5 or more would exceed 9 after
    // the following left shift, so bias it by 3 first.
    function automatic logic [3:0] bcd_adjust(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/alu_result_display_seg7.sv
// -----------------------------------------------------------------------------
// seg7_encode
// Combinational digit code to active-high segment pattern.
//   code    in  4  0..9 decimal digit, 10 = minus, 11 = blank (others blank)
//   pattern out 7  segments {g,f,e,d,c,b,a}, 1 = lit
// -----------------------------------------------------------------------------
module seg7_encode
    import alu_disp_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_BLANK;
        case (code)
            4'd0:       pattern = SEG_0;
            4'd1:       pattern = SEG_1;
            4'd2:       pattern = SEG_2;
            4'd3:       pattern = SEG_3;
            4'd4:       pattern = SEG_4;
            4'd5:       pattern = SEG_5;
            4'd6:       pattern = SEG_6;
            4'd7:       pattern = SEG_7;
            4'd8:       pattern = SEG_8;
            4'd9:       pattern = SEG_9;
            CODE_MINUS: pattern = SEG_MINUS;
            default:    pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/alu_result_display.sv
// -----------------------------------------------------------------------------
// alu_result_display
// Converts the ALU's signed 8-bit result to sign + three BCD digits with a
// sequential double-dabble engine and scans them onto a 4-digit multiplexed
// seven-segment display. A conversion only starts when the sampled result
// differs from the last converted value; display registers are written in a
// single cycle, so a half-converted value is never shown.
//
// There is no valid/ready handshake: result is sampled every cycle, and a
// change arriving while busy is picked up when the FSM returns to IDLE.
//
// Parameters
//   REFRESH_DIV  clk cycles each digit stays enabled (>= 2)
//   ACTIVE_LOW   1: seg and an are active-low; 0: active-high
// Ports
//   clk        in  1  system clock
//   rst_n      in  1  asynchronous active-low reset
//   result     in  8  signed two's-complement ALU result
//   seg        out 7  segment drive {g,f,e,d,c,b,a}, registered
//   an         out 4  digit enables, an[3] = sign (leftmost), registered
//   busy       out 1  conversion in progress (LOAD, SHIFT, DONE)
//   dbg_state  out 2  converter FSM state (conv_state_e encoding)
// -----------------------------------------------------------------------------
module alu_result_display
    import alu_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] result,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       busy,
    output logic [1:0] dbg_state
);

    localparam int              CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    conv_state_e      state, state_nxt;
    logic [7:0]       res_q, last_q;
    logic             neg_q;
    logic [7:0]       mag_q;
    logic [11:0]      bcd_q, bcd_adj;
    logic [2:0]       iter_q;
    logic             disp_neg;
    logic [3:0]       disp_h, disp_t, disp_o;
    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       digit_idx;
    logic [3:0]       cur_code;
    logic [6:0]       cur_pat;
    logic [3:0]       an_onehot;
    logic [6:0]       seg_q;
    logic [3:0]       an_q;

    // ---------------- converter FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (res_q != last_q) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                busy      = 1'b1;
                state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (iter_q == 3'd7) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                busy      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign dbg_state = state;

    assign bcd_adj = {bcd_adjust(bcd_q[11:8]), bcd_adjust(bcd_q[7:4]), bcd_adjust(bcd_q[3:0])};

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q    <= 8'd0;
            last_q   <= 8'd0;
            neg_q    <= 1'b0;
            mag_q    <= 8'd0;
            bcd_q    <= 12'd0;
            iter_q   <= 3'd0;
            disp_neg <= 1'b0;
            disp_h   <= 4'd0;
            disp_t   <= 4'd0;
            disp_o   <= 4'd0;
        end else begin
            res_q <= result;
            case (state)
                ST_LOAD: begin
                    last_q <= res_q;
                    neg_q  <= res_q[7];
                    // Two's-complement negate in 8 bits; -128 maps to 128 unsigned.
                    mag_q  <= res_q[7] ? (~res_q + 8'd1) : res_q;
                    bcd_q  <= 12'd0;
                    iter_q <= 3'd0;
                end
                ST_SHIFT: begin
                    {bcd_q, mag_q} <= {bcd_adj[10:0], mag_q, 1'b0};
                    iter_q         <= iter_q + 3'd1;
                end
                ST_DONE: begin
                    disp_neg <= neg_q;
                    disp_h   <= bcd_q[11:8];
                    disp_t   <= bcd_q[7:4];
                    disp_o   <= bcd_q[3:0];
                end
                default: ;
            endcase
        end
    end

    // ---------------- digit scanner ----------------
    always_comb begin
        cur_code = disp_o;
        case (digit_idx)
            2'd0: cur_code = disp_o;
            2'd1: cur_code = (disp_h == 4'd0 && disp_t == 4'd0) ? CODE_BLANK : disp_t;
            2'd2: cur_code = (disp_h == 4'd0) ? CODE_BLANK : disp_h;
            2'd3: cur_code = disp_neg ? CODE_MINUS : CODE_BLANK;
            default: cur_code = CODE_BLANK;
        endcase
    end

    assign an_onehot = 4'b0001 << digit_idx;

    seg7_encode u_seg7 (
        .code    (cur_code),
        .pattern (cur_pat)
    );

    // an and seg are registered from the same digit index, so they always
    // switch together on one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            digit_idx   <= 2'd0;
            seg_q       <= {7{ACTIVE_LOW}};
            an_q        <= {4{ACTIVE_LOW}};
        end else begin
            if (refresh_cnt == CNT_MAX) begin
                refresh_cnt <= '0;
                digit_idx   <= digit_idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
            seg_q <= cur_pat ^ {7{ACTIVE_LOW}};
            an_q  <= an_onehot ^ {4{ACTIVE_LOW}};
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule
